// File: rtl/if_neuron_scheduler_if.sv
// Input-current stream into the neuron scheduler.
// The source drives data and valid; the scheduler returns ready and the target index.
interface if_neuron_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int IW    = 3
);
  logic [WIDTH-1:0] cur_data;
  logic             cur_valid;
  logic             cur_ready;
  logic [IW-1:0]    cur_idx;

  modport master (
    output cur_data, cur_valid,
    input  cur_ready, cur_idx
  );

  modport slave (
    input  cur_data, cur_valid,
    output cur_ready, cur_idx
  );
endinterface

// File: rtl/if_neuron_scheduler.sv
// One shared integrate-and-fire datapath serving N_NEURONS virtual neurons.
// Define REFRACTORY_EN to blank each neuron for the transfer after it fires.
module if_neuron_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int WIDTH     = 8,
  parameter int THRESHOLD = 230,
  localparam int IW       = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  if_neuron_scheduler_if.slave cur,
  output logic                 busy,
  output logic [N_NEURONS-1:0] spikes,
  output logic                 step_done,
  output logic [15:0]          step_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] THR  = WIDTH'(THRESHOLD);
  localparam logic [IW-1:0]    LAST = IW'(N_NEURONS - 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic [N_NEURONS-1:0] pending;
  logic [WIDTH-1:0]     mem [N_NEURONS];

  logic [WIDTH-1:0]     s;
  logic [WIDTH+1:0]     sum;
  logic [WIDTH-1:0]     mem_nxt;
  logic                 fire;

`ifdef REFRACTORY_EN
  logic [N_NEURONS-1:0] refr;
`endif

  assign cur.cur_ready = (state == RUN);
  assign cur.cur_idx   = idx;
  assign busy          = (state != IDLE);
  assign step_done     = (state == DONE);

  assign s   = mem[idx];
  assign sum = {2'b00, cur.cur_data} + {2'b00, s >> 1}
             + {2'b00, s >> 2} + {2'b00, s >> 3};

  always_comb begin
    fire    = 1'b0;
    mem_nxt = (|sum[WIDTH+1:WIDTH]) ? '1 : sum[WIDTH-1:0];
    if (s >= THR) begin
      fire    = 1'b1;
      mem_nxt = '0;
    end
`ifdef REFRACTORY_EN
    // A blanked transfer swallows the current and leaves the membrane at rest.
    if (refr[idx]) begin
      fire    = 1'b0;
      mem_nxt = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= '0;
      spikes     <= '0;
      step_count <= '0;
      for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            idx   <= '0;
          end
        end
        RUN: begin
          if (cur.cur_valid) begin
            mem[idx]     <= mem_nxt;
            pending[idx] <= fire;
            if (idx == LAST) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          spikes     <= pending;
          pending    <= '0;
          step_count <= step_count + 16'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REFRACTORY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refr <= '0;
    end else if (state == RUN && cur.cur_valid) begin
      refr[idx] <= refr[idx] ? 1'b0 : fire;
    end
  end
`endif

endmodule
